// File: rtl/m92_pkg.sv
// rtl/m92_pkg.sv - shared constants and types for the SDRAM fetch arbiter
// Contents:
//   SDR_ARB_N_REQ      number of video fetch requesters
//   SDR_REQ_*          requester index assignments (0 = sprite fetcher)
//   sdr_arb_state_t    arbiter state encoding {IDLE, WAIT}
//   sdr_arb_idx_w()    index width for a given requester count (never 0)
package m92_pkg;

    localparam int SDR_ARB_N_REQ  = 4;
    localparam int SDR_REQ_SPRITE = 0;
    localparam int SDR_REQ_LAYER0 = 1;
    localparam int SDR_REQ_LAYER1 = 2;
    localparam int SDR_REQ_LAYER2 = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } sdr_arb_state_t;

    function automatic int sdr_arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_fetch_arbiter_rr_picker.sv
// rtl/sdram_fetch_arbiter_rr_picker.sv - round-robin rotate-and-priority-encode
// Ports:
//   pend   in  N_REQ  pending flags
//   last   in  IDX_W  index served most recently; search starts at last+1
//   grant  out IDX_W  first pending index at or after last+1, wrapping
//   any    out 1      at least one pending flag is set
module rr_picker
    import m92_pkg::*;
#(
    parameter int N_REQ = SDR_ARB_N_REQ,
    parameter int IDX_W = sdr_arb_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] pend,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    // k runs 1..N_REQ so that `last` itself is considered last of all.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!any && pend[(int'(last) + k) % N_REQ]) begin
                grant = IDX_W'((int'(last) + k) % N_REQ);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_fetch_arbiter.sv
// rtl/sdram_fetch_arbiter.sv - round-robin sharing of one 64-bit SDRAM read channel
// Optional feature macro: SDR_ARB_TIMEOUT_EN (reissue sdr_req after TIMEOUT idle WAIT cycles)
// Ports (clk_ram domain, synchronous active-high reset):
//   clk_ram   in  1              clock
//   reset     in  1              synchronous reset
//   req       in  N_REQ          single-cycle request pulse per requester
//   req_addr  in  N_REQ*ADDR_W   request addresses, slice i sampled with req[i]
//   rdata     out N_REQ*64       per-requester holding registers
//   rdy       out N_REQ          one-cycle pulse when slice i of rdata updates
//   sdr_addr  out ADDR_W         address to SDRAM controller
//   sdr_req   out 1              one-cycle issue pulse
//   sdr_data  in  64             read data, valid with sdr_rdy
//   sdr_rdy   in  1              one-cycle completion pulse
//   busy      out 1              a transfer is outstanding (WAIT)
module sdram_fetch_arbiter
    import m92_pkg::*;
#(
    parameter int N_REQ   = SDR_ARB_N_REQ,
    parameter int ADDR_W  = 25,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk_ram,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ*64-1:0]     rdata,
    output logic [N_REQ-1:0]        rdy,
    output logic [ADDR_W-1:0]       sdr_addr,
    output logic                    sdr_req,
    input  logic [63:0]             sdr_data,
    input  logic                    sdr_rdy,
    output logic                    busy
);

    localparam int IDX_W = sdr_arb_idx_w(N_REQ);

    sdr_arb_state_t    state, state_next;
    logic [N_REQ-1:0]  pend;
    logic [ADDR_W-1:0] paddr [N_REQ];
    logic              stale;
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  gnt;
    logic [IDX_W-1:0]  pick;
    logic              pick_any;

    logic              do_grant;
    logic              done;
    logic              deliver;
    logic              retry;
    logic              stale_now;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .pend  (pend),
        .last  (last),
        .grant (pick),
        .any   (pick_any)
    );

`ifdef SDR_ARB_TIMEOUT_EN
    localparam int TCNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TCNT_W-1:0] tcnt;
    logic              tcnt_hit;

    assign tcnt_hit = (tcnt == TCNT_W'(TIMEOUT - 1));

    // Counter is zero in the cycle after each issue, so the reissue edge
    // lands exactly TIMEOUT cycles after the previous one.
    always_ff @(posedge clk_ram) begin
        if (reset || do_grant || retry) begin
            tcnt <= '0;
        end else if (state == WAIT) begin
            tcnt <= tcnt + 1'b1;
        end
    end
`else
    logic tcnt_hit;
    assign tcnt_hit = 1'b0;
`endif

    assign busy = (state == WAIT);

    // A re-request from the granted requester in the completion cycle still
    // makes the returning word stale.
    assign stale_now = stale | req[gnt];

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        done       = 1'b0;
        deliver    = 1'b0;
        retry      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    do_grant   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // sdr_rdy cannot belong to a request issued this very cycle.
                if (sdr_rdy && !sdr_req) begin
                    done       = 1'b1;
                    deliver    = !stale_now;
                    state_next = IDLE;
                end else if (tcnt_hit) begin
                    retry = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_ram) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pending addresses need no reset: they are only read behind pend.
    always_ff @(posedge clk_ram) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) begin
                paddr[i] <= req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk_ram) begin
        if (reset) begin
            pend     <= '0;
            stale    <= 1'b0;
            last     <= IDX_W'(N_REQ - 1);
            gnt      <= '0;
            sdr_req  <= 1'b0;
            sdr_addr <= '0;
            rdy      <= '0;
            rdata    <= '0;
        end else begin
            sdr_req <= do_grant | retry;
            rdy     <= '0;

            // A new request wins over the grant's clear of the same flag.
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i]) begin
                    pend[i] <= 1'b1;
                end else if (do_grant && (pick == IDX_W'(i))) begin
                    pend[i] <= 1'b0;
                end
            end

            if (do_grant) begin
                gnt      <= pick;
                sdr_addr <= paddr[pick];
                stale    <= req[pick];
            end else if (state == WAIT && req[gnt]) begin
                stale <= 1'b1;
            end

            if (done) begin
                last <= gnt;
                if (deliver) begin
                    rdata[int'(gnt)*64 +: 64] <= sdr_data;
                    rdy[gnt]                  <= 1'b1;
                end
            end
        end
    end

endmodule
